// File: rtl/bsg_wormhole_traffic_gen_if.sv
// Ready-and flit channel: valid/data from the sender, ready_and back from the receiver.
interface bsg_wormhole_traffic_gen_if #(parameter int flit_width_p = 32);
  logic                    v;
  logic [flit_width_p-1:0] data;
  logic                    ready_and;

  modport master (output v, output data, input  ready_and);
  modport slave  (input  v, input  data, output ready_and);
endinterface

// File: rtl/bsg_wormhole_traffic_gen.sv
// bsg_wormhole_traffic_gen: self-checking wormhole packet source (TX) and sink (RX).
// TX emits sequence-numbered packets whose payload length cycles with the sequence;
// RX checks returned packets for routing fields, order and payload, with a sticky error.
// Optional feature macro: BSG_WORMHOLE_TRAFFIC_GEN_STALL_EN (LFSR-driven TX/RX bubbles).
module bsg_wormhole_traffic_gen #(
  parameter int flit_width_p = 32,
  parameter int cord_width_p = 8,
  parameter int len_width_p  = 4,
  parameter int cid_width_p  = 2,
  parameter int seq_width_p  = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    en_i,
  input  logic [cord_width_p-1:0] my_cord_i,
  input  logic [cid_width_p-1:0]  my_cid_i,
  input  logic [cord_width_p-1:0] dest_cord_i,
  input  logic [cid_width_p-1:0]  dest_cid_i,
  bsg_wormhole_traffic_gen_if.master out_if,
  bsg_wormhole_traffic_gen_if.slave  in_if,
  output logic [31:0]             sent_o,
  output logic [31:0]             received_o,
  output logic                    error_o
);

  // Header field offsets, LSB up: cord | len | dest cid | src cid | seq | pad
  localparam int LEN_LSB  = cord_width_p;
  localparam int DCID_LSB = LEN_LSB + len_width_p;
  localparam int SCID_LSB = DCID_LSB + cid_width_p;
  localparam int SEQ_LSB  = SCID_LSB + cid_width_p;
  localparam int HDR_W    = SEQ_LSB + seq_width_p;
  localparam int PAY_W    = seq_width_p + len_width_p;

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_HDR  = 2'd1;
  localparam logic [1:0] TX_BODY = 2'd2;
  localparam logic [0:0] RX_HDR  = 1'b0;
  localparam logic [0:0] RX_BODY = 1'b1;

  localparam logic [len_width_p-1:0] K_ONE = len_width_p'(1);
  localparam logic [seq_width_p-1:0] S_ONE = seq_width_p'(1);

  if (flit_width_p < HDR_W) begin : g_width_chk
    $error("bsg_wormhole_traffic_gen: flit_width_p too narrow for header fields");
  end

  // ---------------- TX ----------------
  logic [1:0]              r_tx_st;
  logic [seq_width_p-1:0]  r_tx_seq;
  logic [len_width_p-1:0]  r_tx_k;
  logic [cord_width_p-1:0] r_dest_cord;
  logic [cid_width_p-1:0]  r_dest_cid;
  logic [31:0]             r_sent;
  logic [len_width_p-1:0]  w_tx_len;
  logic                    w_tx_v, w_tx_fire, w_tx_gate, w_rx_gate;
  logic [flit_width_p-1:0] w_hdr, w_pay;

`ifdef BSG_WORMHOLE_TRAFFIC_GEN_STALL_EN
  logic [15:0] r_lfsr;
  logic        r_tx_pend;

  // Free-running LFSR (x^16+x^14+x^13+x^11+1) that decides bubble cycles
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) r_lfsr <= 16'hACE1;
    else            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  // Remember an offered-but-unaccepted flit so a bubble can never retract it
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) r_tx_pend <= 1'b0;
    else            r_tx_pend <= w_tx_v & ~out_if.ready_and;
  end

  assign w_tx_gate = r_lfsr[0] | r_tx_pend;
  assign w_rx_gate = r_lfsr[1];
`else
  assign w_tx_gate = 1'b1;
  assign w_rx_gate = 1'b1;
`endif

  // Length is a function of the sequence number, so lengths sweep the full range
  assign w_tx_len  = r_tx_seq[len_width_p-1:0];
  assign w_tx_v    = (r_tx_st != TX_IDLE) & w_tx_gate;
  assign w_tx_fire = w_tx_v & out_if.ready_and;

  // Assemble header and current payload flit
  always_comb begin
    w_hdr = '0;
    w_hdr[LEN_LSB-1:0]          = r_dest_cord;
    w_hdr[DCID_LSB-1:LEN_LSB]   = w_tx_len;
    w_hdr[SCID_LSB-1:DCID_LSB]  = r_dest_cid;
    w_hdr[SEQ_LSB-1:SCID_LSB]   = my_cid_i;
    w_hdr[HDR_W-1:SEQ_LSB]      = r_tx_seq;
    w_pay = '0;
    w_pay[PAY_W-1:0]            = {r_tx_seq, r_tx_k};
  end

  assign out_if.v    = w_tx_v;
  assign out_if.data = (r_tx_st == TX_HDR) ? w_hdr : w_pay;
  assign sent_o      = r_sent;

  // TX packet sequencer: IDLE -> HDR -> BODY(1..len) -> IDLE
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_tx_st     <= TX_IDLE;
      r_tx_seq    <= '0;
      r_tx_k      <= '0;
      r_dest_cord <= '0;
      r_dest_cid  <= '0;
      r_sent      <= '0;
    end else begin
      case (r_tx_st)
        TX_IDLE: if (en_i) begin
          r_tx_st     <= TX_HDR;
          r_tx_k      <= '0;
          r_dest_cord <= dest_cord_i;
          r_dest_cid  <= dest_cid_i;
        end
        TX_HDR: if (w_tx_fire) begin
          if (w_tx_len == '0) begin
            r_tx_st  <= TX_IDLE;
            r_tx_seq <= r_tx_seq + S_ONE;
            r_sent   <= r_sent + 32'd1;
          end else begin
            r_tx_st <= TX_BODY;
            r_tx_k  <= K_ONE;
          end
        end
        TX_BODY: if (w_tx_fire) begin
          if (r_tx_k == w_tx_len) begin
            r_tx_st  <= TX_IDLE;
            r_tx_seq <= r_tx_seq + S_ONE;
            r_sent   <= r_sent + 32'd1;
          end else begin
            r_tx_k <= r_tx_k + K_ONE;
          end
        end
        default: r_tx_st <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  logic [0:0]              r_rx_st;
  logic [seq_width_p-1:0]  r_rx_seq;
  logic [len_width_p-1:0]  r_rx_k, r_rx_len;
  logic [31:0]             r_received;
  logic                    r_error, r_rx_en;
  logic                    w_rx_fire, w_hdr_ok, w_pay_ok;
  logic [len_width_p-1:0]  w_rx_len;
  logic [flit_width_p-1:0] w_exp_pay;

  assign in_if.ready_and = r_rx_en & w_rx_gate;
  assign w_rx_fire       = in_if.v & in_if.ready_and;
  assign w_rx_len        = in_if.data[DCID_LSB-1:LEN_LSB];
  assign w_hdr_ok        = (in_if.data[LEN_LSB-1:0]         == my_cord_i) &&
                           (in_if.data[SCID_LSB-1:DCID_LSB] == my_cid_i)  &&
                           (in_if.data[HDR_W-1:SEQ_LSB]     == r_rx_seq);

  // Expected payload is checked over the full flit so the pad must be zero too
  always_comb begin
    w_exp_pay = '0;
    w_exp_pay[PAY_W-1:0] = {r_rx_seq, r_rx_k};
  end
  assign w_pay_ok = (in_if.data == w_exp_pay);

  assign received_o = r_received;
  assign error_o    = r_error;

  // RX checker: header fields then payload flits; errors are sticky, checking goes on
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_rx_st    <= RX_HDR;
      r_rx_seq   <= '0;
      r_rx_k     <= '0;
      r_rx_len   <= '0;
      r_received <= '0;
      r_error    <= 1'b0;
      r_rx_en    <= 1'b0;
    end else begin
      r_rx_en <= 1'b1;
      if (w_rx_fire) begin
        if (r_rx_st == RX_HDR) begin
          if (!w_hdr_ok) r_error <= 1'b1;
          if (w_rx_len == '0) begin
            r_rx_seq   <= r_rx_seq + S_ONE;
            r_received <= r_received + 32'd1;
          end else begin
            r_rx_st  <= RX_BODY;
            r_rx_len <= w_rx_len;
            r_rx_k   <= K_ONE;
          end
        end else begin
          if (!w_pay_ok) r_error <= 1'b1;
          if (r_rx_k == r_rx_len) begin
            r_rx_st    <= RX_HDR;
            r_rx_seq   <= r_rx_seq + S_ONE;
            r_received <= r_received + 32'd1;
          end else begin
            r_rx_k <= r_rx_k + K_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bsg_wormhole_traffic_gen.sv
// Bench for bsg_wormhole_traffic_gen: directed vector table, loopback/corruption/
// enable-drop/reset sequences, and randomized traffic checked by a packet-level model.
module tb_bsg_wormhole_traffic_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, en, out_rdy, loop, corrupt_en;
  logic [7:0]  my_cord, dest_cord;
  logic [1:0]  my_cid, dest_cid;
  logic [31:0] sent, received;
  logic        error;
  int          n_vec, n_err;

  bsg_wormhole_traffic_gen_if #(.flit_width_p(32)) tx_if();
  bsg_wormhole_traffic_gen_if #(.flit_width_p(32)) rx_if();

  bsg_wormhole_traffic_gen dut (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en),
    .my_cord_i(my_cord), .my_cid_i(my_cid),
    .dest_cord_i(dest_cord), .dest_cid_i(dest_cid),
    .out_if(tx_if), .in_if(rx_if),
    .sent_o(sent), .received_o(received), .error_o(error)
  );

  // Return path: optional loopback, with a one-bit flip on flit 2 of packet 5
  int       rx_pkt, rx_flit;
  logic [3:0] rx_len;
  wire corrupt_now = corrupt_en && (rx_pkt == 5) && (rx_flit == 2);
  assign tx_if.ready_and = loop ? (out_rdy & rx_if.ready_and) : out_rdy;
  assign rx_if.v         = loop & tx_if.v & out_rdy;
  assign rx_if.data      = (loop ? tx_if.data : 32'h0) ^ {31'b0, corrupt_now};

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference flit for packet number seq, flit k (0 = header)
  function automatic logic [31:0] exp_flit(int seq, int k, logic [7:0] c, logic [1:0] dc, logic [1:0] sc);
    int s   = seq % 256;
    int len = seq % 16;
    if (k == 0) return 32'((s << 16) | (int'(sc) << 14) | (int'(dc) << 12) | (len << 8) | int'(c));
    return 32'((s << 4) | k);
  endfunction

  // Packet/flit position on the return path (model of what the DUT receives)
  always @(posedge clk) begin
    if (!reset_n) begin
      rx_pkt <= 0; rx_flit <= 0; rx_len <= 4'd0;
    end else if (rx_if.v && rx_if.ready_and) begin
      if (rx_flit == 0) begin
        if (rx_if.data[11:8] == 4'd0) rx_pkt <= rx_pkt + 1;
        else begin rx_flit <= 1; rx_len <= rx_if.data[11:8]; end
      end else if (rx_flit == int'(rx_len)) begin
        rx_pkt <= rx_pkt + 1; rx_flit <= 0;
      end else rx_flit <= rx_flit + 1;
    end
  end

  // TX model: packet n has n%16 payload flits, one idle cycle between packets,
  // header one cycle after en is seen idle, and held flits never change
  int          m_seq, m_k, m_sent;
  logic        m_live, m_chk_v, m_expv, m_hold;
  logic [31:0] m_hold_data;
  logic [7:0]  m_cord, p_cord;
  logic [1:0]  m_cid, p_cid;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_seq = 0; m_k = 0; m_sent = 0; m_live = 1'b0;
        m_chk_v = 1'b1; m_expv = 1'b0; m_hold = 1'b0;
      end else begin
        check("sent_count", sent, 32'(m_sent));
        if (m_chk_v) check("tx_v_timing", 32'(tx_if.v), 32'(m_expv));
        if (m_hold) begin
          check("hold_v", 32'(tx_if.v), 32'd1);
          check("hold_data", tx_if.data, m_hold_data);
        end
        m_chk_v = 1'b0; m_hold = 1'b0;
        if (tx_if.v) begin
          if (!m_live) begin m_live = 1'b1; m_cord = p_cord; m_cid = p_cid; end
          if (tx_if.ready_and) begin
            check("tx_flit", tx_if.data, exp_flit(m_seq, m_k, m_cord, m_cid, my_cid));
            if (m_k == m_seq % 16) begin
              m_seq++; m_k = 0; m_live = 1'b0; m_sent++;
              m_chk_v = 1'b1; m_expv = 1'b0;
            end else m_k++;
          end else begin
            m_hold = 1'b1; m_hold_data = tx_if.data;
          end
        end else begin
          m_chk_v = 1'b1; m_expv = en;
        end
      end
      p_cord = dest_cord; p_cid = dest_cid;
    end
  end

  typedef struct {
    logic        rst_n, en, rdy;
    logic        exp_v;
    logic [31:0] exp_data;
    logic [31:0] exp_sent;
    logic        exp_irdy;
  } vec_t;
  vec_t tbl[13];

  task automatic tick();
    @(posedge clk); #4;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic reached, err_before;
    logic [31:0] rcv_at;
    n_vec = 0; n_err = 0;
    reset_n = 1'b0; en = 1'b0; out_rdy = 1'b1; loop = 1'b0; corrupt_en = 1'b0;
    my_cord = 8'd6; my_cid = 2'd2; dest_cord = 8'd6; dest_cid = 2'd1;

    // rst en rdy | v data sent irdy   (dest cord 6, dest cid 1, src cid 2)
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'd0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_9006, 32'd0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_9006, 32'd0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        32'd1, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0001_9106, 32'd1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0011, 32'd1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0011, 32'd1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'd2, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'd2, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0002_9206, 32'd2, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0021, 32'd2, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'd0, 1'b0};

    tick();
    for (int i = 0; i < 13; i++) begin
      reset_n = tbl[i].rst_n; en = tbl[i].en; out_rdy = tbl[i].rdy;
      tick();
      check($sformatf("tbl%0d_v", i), 32'(tx_if.v), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v) check($sformatf("tbl%0d_data", i), tx_if.data, tbl[i].exp_data);
      check($sformatf("tbl%0d_sent", i), sent, tbl[i].exp_sent);
      check($sformatf("tbl%0d_irdy", i), 32'(rx_if.ready_and), 32'(tbl[i].exp_irdy));
      check($sformatf("tbl%0d_err", i), 32'(error), 32'd0);
      check($sformatf("tbl%0d_rcv", i), received, 32'd0);
    end

    // Loopback, full rate, 200 cycles
    reset_n = 1'b0; loop = 1'b1; my_cid = 2'd0; dest_cid = 2'd0; en = 1'b0; out_rdy = 1'b1;
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 200; c++) tick();
    en = 1'b0;
    for (int c = 0; c < 40; c++) tick();
    check("t1_sent_eq_rcv", received, sent);
    check("t1_enough", 32'(sent >= 32'd10), 32'd1);
    check("t1_rcv_model", received, 32'(rx_pkt));
    check("t1_err", 32'(error), 32'd0);

    // Randomized enable and backpressure on loopback
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      en = ($urandom % 10) != 0;
      out_rdy = $urandom % 2;
      tick();
    end
    en = 1'b0; out_rdy = 1'b1;
    for (int c = 0; c < 40; c++) tick();
    check("rnd_sent_eq_rcv", received, sent);
    check("rnd_rcv_model", received, 32'(rx_pkt));
    check("rnd_err", 32'(error), 32'd0);

    // Corrupt payload flit 2 of packet 5 on the return path
    do_reset();
    corrupt_en = 1'b1; en = 1'b1; reached = 1'b0; err_before = 1'b1;
    for (int c = 0; c < 400 && !reached; c++) begin
      tick();
      if (rx_pkt == 5 && rx_flit == 2) err_before = error;
      if (rx_pkt == 5 && rx_flit == 3) reached = 1'b1;
    end
    check("t3_reached", 32'(reached), 32'd1);
    check("t3_err_before", 32'(err_before), 32'd0);
    check("t3_err_after", 32'(error), 32'd1);
    rcv_at = received;
    for (int c = 0; c < 60; c++) tick();
    corrupt_en = 1'b0;
    check("t3_err_sticky", 32'(error), 32'd1);
    check("t3_rcv_grows", 32'(received > rcv_at), 32'd1);
    check("t3_rcv_model", received, 32'(rx_pkt));

    // Drop enable during the body of packet 15
    do_reset();
    en = 1'b1; reached = 1'b0;
    for (int c = 0; c < 2000 && !reached; c++) begin
      tick();
      if (m_seq == 15 && m_k >= 1) reached = 1'b1;
    end
    check("t4_reached", 32'(reached), 32'd1);
    en = 1'b0;
    for (int c = 0; c < 40; c++) tick();
    check("t4_sent", sent, 32'd16);
    check("t4_v_low", 32'(tx_if.v), 32'd0);
    check("t4_rcv", received, 32'd16);
    check("t4_err", 32'(error), 32'd0);

    // Reset in the middle of a packet body, then clean restart
    do_reset();
    en = 1'b1; reached = 1'b0;
    for (int c = 0; c < 400 && !reached; c++) begin
      tick();
      if (m_seq == 4 && m_k >= 2) reached = 1'b1;
    end
    check("t5_reached", 32'(reached), 32'd1);
    reset_n = 1'b0;
    tick();
    check("t5_v", 32'(tx_if.v), 32'd0);
    check("t5_sent", sent, 32'd0);
    check("t5_rcv", received, 32'd0);
    check("t5_irdy", 32'(rx_if.ready_and), 32'd0);
    reset_n = 1'b1;
    for (int c = 0; c < 150; c++) tick();
    en = 1'b0;
    for (int c = 0; c < 40; c++) tick();
    check("t5_err", 32'(error), 32'd0);
    check("t5_sent_eq_rcv", received, sent);
    check("t5_rcv_pos", 32'(received > 32'd0), 32'd1);

    // TX only with destination changing every cycle
    reset_n = 1'b0; loop = 1'b0; my_cid = 2'd3;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      en = ($urandom % 4) != 0;
      out_rdy = $urandom % 2;
      dest_cord = 8'($urandom);
      dest_cid = 2'($urandom);
      tick();
    end
    check("dst_rcv", received, 32'd0);
    check("dst_err", 32'(error), 32'd0);
    check("dst_some_sent", 32'(sent > 32'd0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
